// File: rtl/divi_arbiter.sv
// divi_arbiter
//   Round-robin front end that shares one pipelined divider core between
//   N_REQ requesters. It accepts at most one request per cycle, drives the
//   core, carries each operation's requester ID down a tag pipeline that
//   matches the core latency, and steers every result back to its owner.
//
// Handshake: a request transfers on a cycle where req_valid[i] and
//   req_ready[i] are both 1. req_ready is combinational, one-hot or zero,
//   and is only raised while core_rfd=1 and reset is released. Responses
//   have no backpressure: rsp_valid is a one-cycle one-hot strobe.
//
// Optional feature: define DIVI_ZERO_CHK_EN to trap divide-by-zero locally.
//   A trapped request is not sent to the core. It still occupies a tag slot,
//   so it returns quotient 25'h1FFFFFF, fractional 0, rsp_err=1 with the
//   normal latency. Without the macro, rsp_err is tied 0.
//
// Ports:
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   req_valid/req_ready       per-requester handshake
//   req_dividend/req_divisor  packed operands, requester i at [25i+:25] / [16i+:16]
//   core_rfd                  core ready for data
//   core_nd, core_dividend,
//   core_divisor              new-data strobe and operands to the core
//   core_quotient,
//   core_fractional           core results, valid DIV_LAT cycles after core_nd
//   rsp_valid, rsp_id,
//   rsp_quotient,
//   rsp_fractional, rsp_err   registered response to the requester
//   busy                      at least one operation in flight

module divi_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int DIV_LAT = 28
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*25-1:0]   req_dividend,
    input  logic [N_REQ*16-1:0]   req_divisor,
    input  logic                  core_rfd,
    output logic                  core_nd,
    output logic [24:0]           core_dividend,
    output logic [15:0]           core_divisor,
    input  logic [24:0]           core_quotient,
    input  logic [15:0]           core_fractional,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [24:0]           rsp_quotient,
    output logic [15:0]           rsp_fractional,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam logic [ID_W:0]   N_REQ_X = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W:0]    cand;
    logic             found;
    logic             grant_vld;
    logic [ID_W-1:0]  grant_id;
    logic [24:0]      sel_dividend;
    logic [15:0]      sel_divisor;
    logic             accept;
    logic             issue;

    logic [DIV_LAT:0] tag_v;
    logic [ID_W-1:0]  tag_id [0:DIV_LAT];
    logic [N_REQ-1:0] rsp_onehot;

    // Round-robin search: candidate k is (rr_ptr + k) mod N_REQ, the first
    // valid candidate wins. The modulo is a single conditional subtract
    // because rr_ptr + k never reaches 2*N_REQ.
    always_comb begin
        found    = 1'b0;
        cand     = '0;
        grant_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= N_REQ_X) begin
                cand = cand - N_REQ_X;
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req_valid[j] && (cand == (ID_W+1)'(j))) begin
                    found    = 1'b1;
                    grant_id = ID_W'(j);
                end
            end
        end
        grant_vld = found && core_rfd && sys_rst_n;
    end

    // Ready decode and operand mux for the winner.
    always_comb begin
        req_ready    = '0;
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (grant_id == ID_W'(j)) begin
                sel_dividend = req_dividend[j*25 +: 25];
                sel_divisor  = req_divisor[j*16 +: 16];
                req_ready[j] = grant_vld;
            end
        end
    end

    // The grant only exists where the winner is valid, so ready implies a
    // transfer.
    assign accept = grant_vld;

`ifdef DIVI_ZERO_CHK_EN
    logic             sel_zero;
    logic [DIV_LAT:0] tag_err;

    assign sel_zero = (sel_divisor == 16'd0);
    // A trapped divide still takes a tag slot but never reaches the core.
    assign issue    = accept && !sel_zero;

    always_ff @(posedge sys_clk) begin
        tag_err <= {tag_err[DIV_LAT-1:0], sel_zero};
    end
`else
    assign issue   = accept;
    assign rsp_err = 1'b0;
`endif

    // Issue side: core strobe, operand registers, pointer, tag valid bits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rr_ptr        <= '0;
            core_nd       <= 1'b0;
            core_dividend <= '0;
            core_divisor  <= '0;
            tag_v         <= '0;
            busy          <= 1'b0;
        end else begin
            core_nd <= issue;
            // The core never stalls, so tags advance every cycle.
            tag_v   <= {tag_v[DIV_LAT-1:0], accept};
            busy    <= |tag_v;
            if (accept) begin
                core_dividend <= sel_dividend;
                core_divisor  <= sel_divisor;
                rr_ptr        <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
            end
        end
    end

    // IDs only matter where the matching valid bit is set, so no reset.
    always_ff @(posedge sys_clk) begin
        tag_id[0] <= grant_id;
        for (int s = 1; s <= DIV_LAT; s++) begin
            tag_id[s] <= tag_id[s-1];
        end
    end

    always_comb begin
        rsp_onehot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            rsp_onehot[j] = (tag_id[DIV_LAT] == ID_W'(j));
        end
    end

    // Last tag stage lines up with the core result; capture it here.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rsp_valid      <= '0;
            rsp_id         <= '0;
            rsp_quotient   <= '0;
            rsp_fractional <= '0;
`ifdef DIVI_ZERO_CHK_EN
            rsp_err        <= 1'b0;
`endif
        end else if (tag_v[DIV_LAT]) begin
            rsp_valid <= rsp_onehot;
            rsp_id    <= tag_id[DIV_LAT];
`ifdef DIVI_ZERO_CHK_EN
            if (tag_err[DIV_LAT]) begin
                rsp_quotient   <= 25'h1FFFFFF;
                rsp_fractional <= 16'd0;
                rsp_err        <= 1'b1;
            end else begin
                rsp_quotient   <= core_quotient;
                rsp_fractional <= core_fractional;
                rsp_err        <= 1'b0;
            end
`else
            rsp_quotient   <= core_quotient;
            rsp_fractional <= core_fractional;
`endif
        end else begin
            rsp_valid <= '0;
        end
    end

endmodule

// File: tb/tb_divi_arbiter.sv
// tb_divi_arbiter
//   Directed bench for divi_arbiter (N_REQ=4, ID_W=2, DIV_LAT=28) with a
//   behavioural divider core. Expected grants and results are hand-computed
//   in the stimulus; responses are matched against an expected queue that
//   also records the cycle each response is due.

module tb_divi_arbiter;

    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 28;
    localparam int EXPW = 76;   // {due[31:0], id[1:0], err, quo[24:0], frac[15:0]}

`ifdef DIVI_ZERO_CHK_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic           clk;
    logic           sys_rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*25-1:0] req_dividend;
    logic [N*16-1:0] req_divisor;
    logic           core_rfd;
    logic           core_nd;
    logic [24:0]    core_dividend;
    logic [15:0]    core_divisor;
    logic [24:0]    core_quotient;
    logic [15:0]    core_fractional;
    logic [N-1:0]   rsp_valid;
    logic [IDW-1:0] rsp_id;
    logic [24:0]    rsp_quotient;
    logic [15:0]    rsp_fractional;
    logic           rsp_err;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [EXPW-1:0] exp_q[$];

    logic [24:0] op_dvd  [N];
    logic [15:0] op_dvs  [N];
    logic [24:0] op_quo  [N];
    logic [15:0] op_frac [N];

    logic        nd_exp;
    logic [24:0] nd_dvd;
    logic [15:0] nd_dvs;

    divi_arbiter #(.N_REQ(N), .ID_W(IDW), .DIV_LAT(LAT)) dut (
        .sys_clk        (clk),
        .sys_rst_n      (sys_rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .core_rfd       (core_rfd),
        .core_nd        (core_nd),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_quotient  (core_quotient),
        .core_fractional(core_fractional),
        .rsp_valid      (rsp_valid),
        .rsp_id         (rsp_id),
        .rsp_quotient   (rsp_quotient),
        .rsp_fractional (rsp_fractional),
        .rsp_err        (rsp_err),
        .busy           (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural divider core ----------------
    // Result of a core_nd cycle appears LAT cycles later; idle slots carry
    // junk so a DUT that samples the wrong cycle is caught.
    logic [24:0] pipe_q [LAT];
    logic [15:0] pipe_f [LAT];

    always @(posedge clk) begin
        if (core_nd) begin
            if (core_divisor == 16'd0) begin
                pipe_q[0] <= 25'd0;
                pipe_f[0] <= 16'd0;
            end else begin
                pipe_q[0] <= core_dividend / 25'(core_divisor);
                pipe_f[0] <= 16'((41'(core_dividend % 25'(core_divisor)) << 16) / 41'(core_divisor));
            end
        end else begin
            pipe_q[0] <= 25'h0AAAAAA;
            pipe_f[0] <= 16'h5555;
        end
        for (int i = 1; i < LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
            pipe_f[i] <= pipe_f[i-1];
        end
    end

    assign core_quotient   = pipe_q[LAT-1];
    assign core_fractional = pipe_f[LAT-1];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a response must appear exactly on its due cycle; any
    // other cycle must have rsp_valid low.
    always @(negedge clk) begin
        logic [EXPW-1:0] e;
        if (exp_q.size() > 0 && exp_q[0][75:44] == 32'(cyc)) begin
            e = exp_q.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'(4'b0001 << e[43:42]));
            check("rsp_id", 32'(rsp_id), 32'(e[43:42]));
            check("rsp_err", 32'(rsp_err), 32'(e[41]));
            check("rsp_quotient", 32'(rsp_quotient), 32'(e[40:16]));
            check("rsp_fractional", 32'(rsp_fractional), 32'(e[15:0]));
        end else begin
            check("rsp_idle", 32'(rsp_valid), 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_op(input int i, input logic [24:0] dvd, input logic [15:0] dvs,
                          input logic [24:0] quo, input logic [15:0] frac);
        op_dvd[i]  = dvd;
        op_dvs[i]  = dvs;
        op_quo[i]  = quo;
        op_frac[i] = frac;
        req_dividend[i*25 +: 25] = dvd;
        req_divisor[i*16 +: 16]  = dvs;
    endtask

    // One cycle: drive inputs, check the grant, check core_nd from the
    // previous cycle's grant, and record the expected response.
    task automatic step(input logic [N-1:0] v, input logic rfd, input logic [N-1:0] exp_rdy,
                        input string tag);
        int  id;
        logic err;
        @(posedge clk);
        #1;
        req_valid = v;
        core_rfd  = rfd;
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        check({tag, "_core_nd"}, 32'(core_nd), 32'(nd_exp));
        if (nd_exp) begin
            check({tag, "_core_dividend"}, 32'(core_dividend), 32'(nd_dvd));
            check({tag, "_core_divisor"}, 32'(core_divisor), 32'(nd_dvs));
        end
        nd_exp = 1'b0;
        if (exp_rdy != '0) begin
            id = 0;
            for (int j = 0; j < N; j++) if (exp_rdy[j]) id = j;
            err    = ZERO_EN && (op_dvs[id] == 16'd0);
            nd_exp = !err;
            nd_dvd = op_dvd[id];
            nd_dvs = op_dvs[id];
            exp_q.push_back({32'(cyc + LAT + 2), 2'(id), err, op_quo[id], op_frac[id]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b1, '0, "idle");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        sys_rst_n = 1'b0;
        req_valid = '0;
        exp_q.delete();
        nd_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_core_nd"}, 32'(core_nd), 32'd0);
        check({tag, "_core_dividend"}, 32'(core_dividend), 32'd0);
        check({tag, "_core_divisor"}, 32'(core_divisor), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_quotient"}, 32'(rsp_quotient), 32'd0);
        check({tag, "_rsp_fractional"}, 32'(rsp_fractional), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        sys_rst_n    = 1'b0;
        req_valid    = 4'b1111;
        core_rfd     = 1'b1;
        req_dividend = '0;
        req_divisor  = '0;
        nd_exp       = 1'b0;
        nd_dvd       = '0;
        nd_dvs       = '0;
        set_op(0, 25'd120,  16'd10, 25'd12, 16'd0);
        set_op(1, 25'd200,  16'd8,  25'd25, 16'd0);
        set_op(2, 25'd99,   16'd9,  25'd11, 16'd0);
        set_op(3, 25'd1000, 16'd25, 25'd40, 16'd0);

        // Reset state, with every requester asking.
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        req_valid = '0;

        // Single request 120/10 from requester 0.
        step(4'b0001, 1'b1, 4'b0001, "single");
        idle(3);
        check("busy_in_flight", 32'(busy), 32'd1);
        idle(32);
        check("busy_drained", 32'(busy), 32'd0);

        // All four continuously: grants 0,1,2,3,0,1,2,3 from a fresh pointer.
        do_reset();
        step(4'b1111, 1'b1, 4'b0001, "all4_0");
        step(4'b1111, 1'b1, 4'b0010, "all4_1");
        step(4'b1111, 1'b1, 4'b0100, "all4_2");
        step(4'b1111, 1'b1, 4'b1000, "all4_3");
        step(4'b1111, 1'b1, 4'b0001, "all4_4");
        step(4'b1111, 1'b1, 4'b0010, "all4_5");
        step(4'b1111, 1'b1, 4'b0100, "all4_6");
        step(4'b1111, 1'b1, 4'b1000, "all4_7");
        idle(24);

        // core_rfd low for 5 cycles while all request; the earlier
        // batch returns during this window.
        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 4'b0000, "rfd_low");
        step(4'b1111, 1'b1, 4'b0001, "rfd_back");
        idle(32);

        // Requester 2 streams 10 ops; pointer sits at 3 afterwards, so
        // requester 1 wins after the wrap, then 2.
        for (int i = 0; i < 10; i++) step(4'b0100, 1'b1, 4'b0100, "stream2");
        step(4'b0110, 1'b1, 4'b0010, "wrap_r1");
        step(4'b0110, 1'b1, 4'b0100, "wrap_r2");
        idle(32);

        // Divide by zero from requester 3 (pointer is at 3).
`ifdef DIVI_ZERO_CHK_EN
        set_op(3, 25'd500, 16'd0, 25'h1FFFFFF, 16'd0);
`else
        set_op(3, 25'd500, 16'd0, 25'd0, 16'd0);
`endif
        step(4'b1000, 1'b1, 4'b1000, "div0");
        idle(32);

        // Five operations in flight, then reset.
        set_op(3, 25'd1000, 16'd25, 25'd40, 16'd0);
        step(4'b1111, 1'b1, 4'b0001, "pre_rst_0");
        step(4'b1111, 1'b1, 4'b0010, "pre_rst_1");
        step(4'b1111, 1'b1, 4'b0100, "pre_rst_2");
        step(4'b1111, 1'b1, 4'b1000, "pre_rst_3");
        step(4'b1111, 1'b1, 4'b0001, "pre_rst_4");
        @(posedge clk);
        #2;
        sys_rst_n = 1'b0;
        req_valid = 4'b1111;
        exp_q.delete();
        nd_exp = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        req_valid = '0;
        idle(40);

        // Fresh work after reset: 120/10 and 7/2 (3 remainder 1 -> 0x8000).
        set_op(1, 25'd7, 16'd2, 25'd3, 16'h8000);
        step(4'b0001, 1'b1, 4'b0001, "post_rst_0");
        step(4'b0010, 1'b1, 4'b0010, "post_rst_1");
        idle(34);
        check("final_busy", 32'(busy), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
